spin_readout: RTL and testbench
===============================

SPIN_READOUT -- requirements
Module: spin_readout

Interface
REQ-001 Parameter N, default 3: number of oscillators (spins) read from the coupled-oscillator array.
REQ-002 Parameter SETTLE_CYCLES, default 1024: clk cycles the array anneals before measurement.
REQ-003 Parameter WINDOW_LOG2, default 8: measurement window is 2^WINDOW_LOG2 clk cycles.
REQ-004 Parameter RST_CYCLES, default 4: clk cycles core_rstn is held low per run.
REQ-005 clk  input  1  single clock; all state on its rising edge.
REQ-006 rstn  input  1  asynchronous, active-low reset.
REQ-007 start  input  1  run request, sampled each cycle.
REQ-008 abort  input  1  cancel the current run.
REQ-009 osc_in  input  N  oscillator outputs from the array, asynchronous to clk.
REQ-010 core_rstn  output  1  active-low reset driven to the oscillator array.
REQ-011 busy  output  1  high while a run is in progress.
REQ-012 valid  output  1  spins holds a completed result.
REQ-013 spins  output  N  measured spin vector; bit 0 is the phase reference.

Function
REQ-014 Each osc_in bit SHALL pass through a 2-flop synchronizer before use; synchronizer latency is 2 cycles.
REQ-015 FSM states: IDLE, RST, SETTLE, MEASURE, DONE.
- IDLE/DONE + start -> RST.
- RST -> SETTLE after RST_CYCLES cycles.
- SETTLE -> MEASURE after SETTLE_CYCLES cycles.
- MEASURE -> DONE after 2^WINDOW_LOG2 cycles.
REQ-016 In RST, core_rstn SHALL be 0; in SETTLE, MEASURE and DONE it SHALL be 1; in IDLE it SHALL be 0.
REQ-017 busy SHALL be 1 in RST, SETTLE and MEASURE, and 0 otherwise.
REQ-018 On the cycle start is accepted, valid SHALL go to 0, and spins SHALL hold its last value.
REQ-019 While busy, start SHALL be ignored.
REQ-020 abort while busy SHALL go to IDLE on the next cycle, leaving valid=0 and spins unchanged; abort in IDLE/DONE SHALL be ignored.
REQ-021 Simultaneous start and abort in IDLE/DONE: start SHALL win.
REQ-022 Per-spin mismatch counters i=1..N-1, width WINDOW_LOG2+1 (no wrap):
- cleared on entry to MEASURE;
- incremented each MEASURE cycle in which sync(osc_in[i]) XOR sync(osc_in[0]) = 1.
REQ-023 On the MEASURE->DONE transition, spins[i] SHALL be loaded with (count_i > 2^(WINDOW_LOG2-1)); a count exactly equal to half SHALL give 0.
REQ-024 spins[0] SHALL always be 0.
REQ-025 valid SHALL rise in the first DONE cycle and stay high until the next accepted start.
REQ-026 Run latency, start accepted to valid=1, SHALL be exactly 1+RST_CYCLES+SETTLE_CYCLES+2^WINDOW_LOG2 cycles.

Reset
REQ-027 rstn=0 SHALL asynchronously force:
- state IDLE, core_rstn=0, busy=0, valid=0;
- spins=0, all counters and synchronizer flops 0.
REQ-028 Reset mid-run SHALL discard the run; after reset, no result SHALL appear without a new start.

Configuration
REQ-029 Macro SPIN_READOUT_DEGLITCH_EN defined:
- each synchronized bit SHALL pass a 3-sample majority filter before comparison;
- this adds 2 cycles of input latency;
- cycle counts in REQ-026 SHALL be unchanged.
REQ-030 Macro SPIN_READOUT_DEGLITCH_EN undefined: the synchronizer output SHALL feed the comparison directly.

Structure
REQ-031 A shared package spin_readout_pkg SHALL hold the FSM state typedef and the counter-width function of WINDOW_LOG2.
REQ-032 The per-bit synchronizer (plus optional majority filter) SHALL be a sub-module named osc_sync, instantiated N times.

Verification
REQ-033 N=3, WINDOW_LOG2=4, SETTLE_CYCLES=8, all osc_in in phase; start -> valid after 29 cycles, spins=3'b000.
REQ-034 osc_in[2] = inverted osc_in[0], osc_in[1] in phase -> spins=3'b100; osc_in[1] also inverted -> spins=3'b110.
REQ-035 osc_in[1] 90 degrees offset (exactly 8 of 16 mismatches) -> spins[1]=0; 9 of 16 mismatches -> spins[1]=1.
REQ-036 Pulse start in SETTLE -> ignored, same latency; abort in MEASURE -> IDLE next cycle, busy=0, valid=0, core_rstn=0.
REQ-037 rstn low during MEASURE -> all outputs 0 immediately; no valid pulse after release until start.
REQ-038 With SPIN_READOUT_DEGLITCH_EN, a 1-cycle glitch on in-phase osc_in[1] each 4 cycles -> spins=3'b000; without the macro, 4 mismatches counted.

Source files
------------

// File: rtl/spin_readout_pkg.sv
// Shared types for the spin readout block.
// FSM state encoding and counter sizing helper.
package spin_readout_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RST,
    SETTLE,
    MEASURE,
    DONE
  } state_t;

  // A full window of mismatches must fit without wrapping.
  function automatic int cnt_width(input int window_log2);
    return window_log2 + 1;
  endfunction

endpackage

// File: rtl/osc_sync.sv
// Per-oscillator two-flop synchronizer.
// Optional majority deglitch: SPIN_READOUT_DEGLITCH_EN.
module osc_sync (
  input  logic clk,
  input  logic rstn,
  input  logic din,
  output logic dout
);

  logic [1:0] sync;

  // Two-flop synchronizer for the asynchronous oscillator bit.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) sync <= '0;
    else       sync <= {sync[0], din};
  end

`ifdef SPIN_READOUT_DEGLITCH_EN
  logic [2:0] hist;

  // Three-sample history; the vote is centred on hist[1].
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) hist <= '0;
    else       hist <= {hist[1:0], sync[1]};
  end

  assign dout = (hist[0] & hist[1]) |
                (hist[1] & hist[2]) |
                (hist[0] & hist[2]);
`else
  assign dout = sync[1];
`endif

endmodule

// File: rtl/spin_readout.sv
// Coupled-oscillator array readout: reset, anneal, measure.
// Build option: SPIN_READOUT_DEGLITCH_EN (majority filter).
module spin_readout
  import spin_readout_pkg::*;
#(
  parameter int N             = 3,
  parameter int SETTLE_CYCLES = 1024,
  parameter int WINDOW_LOG2   = 8,
  parameter int RST_CYCLES    = 4
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         start,
  input  logic         abort,
  input  logic [N-1:0] osc_in,
  output logic         core_rstn,
  output logic         busy,
  output logic         valid,
  output logic [N-1:0] spins
);

  localparam int CW   = cnt_width(WINDOW_LOG2);
  localparam int WIN  = 2 ** WINDOW_LOG2;
  localparam int HALF = 2 ** (WINDOW_LOG2 - 1);
  localparam int M1   = (RST_CYCLES > SETTLE_CYCLES) ?
                        RST_CYCLES : SETTLE_CYCLES;
  localparam int TMAX = (M1 > WIN) ? M1 : WIN;
  localparam int TW   = $clog2(TMAX + 1);

  state_t          state;
  logic [TW-1:0]   timer;
  logic [N-1:0]    osc_s;
  logic [CW-1:0]   cnt     [1:N-1];
  logic [CW-1:0]   cnt_inc [1:N-1];
  logic [N-1:0]    hit;

  for (genvar g = 0; g < N; g++) begin : g_sync
    osc_sync u_sync (
      .clk  (clk),
      .rstn (rstn),
      .din  (osc_in[g]),
      .dout (osc_s[g])
    );
  end

  // Next mismatch counts and the majority decision per spin.
  always_comb begin
    hit = '0;
    for (int i = 1; i < N; i++) begin
      cnt_inc[i] = cnt[i] + {{(CW-1){1'b0}}, osc_s[i] ^ osc_s[0]};
      hit[i]     = cnt_inc[i] > CW'(HALF);
    end
  end

  // Run sequencer with registered outputs and mismatch counters.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      timer     <= '0;
      core_rstn <= 1'b0;
      busy      <= 1'b0;
      valid     <= 1'b0;
      spins     <= '0;
      for (int i = 1; i < N; i++) cnt[i] <= '0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            state     <= RST;
            timer     <= '0;
            core_rstn <= 1'b0;
            busy      <= 1'b1;
            valid     <= 1'b0;
          end
        end
        RST: begin
          if (abort) begin
            state     <= IDLE;
            core_rstn <= 1'b0;
            busy      <= 1'b0;
          end else if (timer == TW'(RST_CYCLES - 1)) begin
            state     <= SETTLE;
            timer     <= '0;
            core_rstn <= 1'b1;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        SETTLE: begin
          if (abort) begin
            state     <= IDLE;
            core_rstn <= 1'b0;
            busy      <= 1'b0;
          end else if (timer == TW'(SETTLE_CYCLES - 1)) begin
            state <= MEASURE;
            timer <= '0;
            for (int i = 1; i < N; i++) cnt[i] <= '0;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        MEASURE: begin
          if (abort) begin
            state     <= IDLE;
            core_rstn <= 1'b0;
            busy      <= 1'b0;
          end else begin
            for (int i = 1; i < N; i++) cnt[i] <= cnt_inc[i];
            if (timer == TW'(WIN - 1)) begin
              state <= DONE;
              timer <= '0;
              busy  <= 1'b0;
              valid <= 1'b1;
              spins <= hit;
            end else begin
              timer <= timer + TW'(1);
            end
          end
        end
        default: begin
          state     <= IDLE;
          core_rstn <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spin_readout.sv
// Randomized scoreboard bench for spin_readout.
// Model follows SPIN_READOUT_DEGLITCH_EN when defined.
module tb_spin_readout;

  localparam int N      = 3;
  localparam int WL2    = 4;
  localparam int SETTLE = 8;
  localparam int RSTC   = 4;
  localparam int WIN    = 2 ** WL2;
  localparam int HALF   = 2 ** (WL2 - 1);
  localparam int LAT    = 1 + RSTC + SETTLE + WIN;
  localparam int RUNLEN = 40;
`ifdef SPIN_READOUT_DEGLITCH_EN
  localparam int WS = RSTC + SETTLE - 2 + 2;
`else
  localparam int WS = RSTC + SETTLE - 2;
`endif

  typedef struct {
    logic [N-1:0] spins;
    int           lat;
  } exp_t;

  logic         clk = 1'b0;
  logic         rstn;
  logic         start;
  logic         abort;
  logic [N-1:0] osc_in;
  logic         core_rstn;
  logic         busy;
  logic         valid;
  logic [N-1:0] spins;

  int           checks = 0;
  int           errors = 0;
  int           cyc = 0;
  int           acc = 0;
  logic         vprev = 1'b0;
  logic [N-1:0] last_spins = '0;
  logic [N-1:0] wv [0:RUNLEN-1];
  exp_t         sb [$];

  spin_readout #(
    .N             (N),
    .SETTLE_CYCLES (SETTLE),
    .WINDOW_LOG2   (WL2),
    .RST_CYCLES    (RSTC)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .start     (start),
    .abort     (abort),
    .osc_in    (osc_in),
    .core_rstn (core_rstn),
    .busy      (busy),
    .valid     (valid),
    .spins     (spins)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Value of oscillator bit i as the comparator sees it at window slot idx.
  function automatic logic seen(input int idx, input int i);
`ifdef SPIN_READOUT_DEGLITCH_EN
    int s;
    s = int'(wv[idx-1][i]) + int'(wv[idx][i]) + int'(wv[idx+1][i]);
    return s >= 2;
`else
    return wv[idx][i];
`endif
  endfunction

  function automatic logic [N-1:0] model();
    logic [N-1:0] r;
    r = '0;
    for (int i = 1; i < N; i++) begin
      int c;
      c = 0;
      for (int j = 0; j < WIN; j++)
        if (seen(WS + j, i) != seen(WS + j, 0)) c++;
      r[i] = (c > HALF);
    end
    return r;
  endfunction

  // Random waveform with exactly k1/k2 mismatches inside the window.
  task automatic make_wave(input int k1, input int k2);
    int ks [1:2];
    ks[1] = k1;
    ks[2] = k2;
    for (int k = 0; k < RUNLEN; k++) wv[k] = N'($urandom);
    for (int i = 1; i < N; i++) begin
      logic m [0:WIN-1];
      for (int j = 0; j < WIN; j++) m[j] = (j < ks[i]);
      for (int j = WIN - 1; j > 0; j--) begin
        int r;
        logic t;
        r = $urandom_range(0, j);
        t = m[j]; m[j] = m[r]; m[r] = t;
      end
      for (int j = 0; j < WIN; j++)
        wv[WS + j][i] = wv[WS + j][0] ^ m[j];
    end
  endtask

  // mode 0 normal, 1 start in SETTLE, 2 abort in MEASURE,
  // 3 reset in MEASURE, 4 start and abort together.
  task automatic run(input int mode);
    exp_t e;
    logic completes;
    completes = (mode == 0) || (mode == 1) || (mode == 4);
    e.spins = model();
    e.lat   = LAT;
    start = 1'b1;
    abort = (mode == 4);
    if (completes) sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    acc = cyc;
    for (int k = 0; k < RUNLEN; k++) begin
      osc_in = wv[k];
      if (k == 0) begin
        chk("rst_busy", 32'(busy), 1);
        chk("rst_core_rstn", 32'(core_rstn), 0);
        chk("start_valid", 32'(valid), 0);
        chk("start_spins_hold", 32'(spins), 32'(last_spins));
      end
      if (k == RSTC) begin
        chk("settle_core_rstn", 32'(core_rstn), 1);
        chk("settle_busy", 32'(busy), 1);
      end
      if (mode == 1 && k == 6) start = 1'b1;
      if (mode == 1 && k == 7) start = 1'b0;
      if (mode == 2 && k == 15) abort = 1'b1;
      if (mode == 2 && k == 16) begin
        abort = 1'b0;
        chk("abort_busy", 32'(busy), 0);
        chk("abort_valid", 32'(valid), 0);
        chk("abort_core_rstn", 32'(core_rstn), 0);
        chk("abort_spins", 32'(spins), 32'(last_spins));
      end
      if (mode == 3 && k == 16) begin
        rstn = 1'b0;
        #1;
        chk("areset_out", 32'({core_rstn, busy, valid, spins}), 0);
        last_spins = '0;
      end
      if (mode == 3 && k == 18) rstn = 1'b1;
      if (completes && k == LAT - 1) begin
        chk("done_valid", 32'(valid), 1);
        chk("done_busy", 32'(busy), 0);
        chk("done_core_rstn", 32'(core_rstn), 1);
      end
      if (completes && k == 30) abort = 1'b1;
      if (completes && k == 31) begin
        abort = 1'b0;
        chk("done_abort_valid", 32'(valid), 1);
        chk("done_abort_busy", 32'(busy), 0);
      end
      @(negedge clk);
    end
    if (completes) last_spins = e.spins;
  endtask

  // Scoreboard monitor: pops on every rising valid.
  always @(negedge clk) begin
    if (valid && !vprev) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid actual=1 required=0");
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("spins", 32'(spins), 32'(e.spins));
        chk("latency", 32'(cyc - acc + 1), 32'(e.lat));
      end
    end
    vprev = valid;
  end

  initial begin
    rstn   = 1'b0;
    start  = 1'b0;
    abort  = 1'b0;
    osc_in = '0;
    repeat (3) @(negedge clk);
    chk("reset_core_rstn", 32'(core_rstn), 0);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_valid", 32'(valid), 0);
    chk("reset_spins", 32'(spins), 0);
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    make_wave(0, 0);   run(0);
    make_wave(0, 16);  run(0);
    make_wave(16, 16); run(0);
    make_wave(8, 9);   run(0);
    make_wave(9, 8);   run(0);
    make_wave(12, 3);  run(1);
    make_wave(16, 0);  run(2);
    make_wave(5, 11);  run(4);
    make_wave(16, 16); run(3);
    for (int r = 0; r < 8; r++) begin
      make_wave($urandom_range(0, WIN), $urandom_range(0, WIN));
      run(0);
    end

    repeat (5) @(negedge clk);
    chk("sb_pending", 32'(sb.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
